// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: pipeline register clear codes and hazard controller state encoding
package pipe_ctrl_pkg;
  localparam logic [1:0] CLR_RUN = 2'b00;
  localparam logic [1:0] CLR_HOLD = 2'b01;
  localparam logic [1:0] CLR_FLUSH = 2'b11;
  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-cycle pipeline clear codes and PC enable from load-use, branch, multi-cycle and memory-wait hazards
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int MC_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             ex_mc_start,
  input  logic [MC_W-1:0]  ex_mc_lat,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic [1:0]       clr_ifid,
  output logic [1:0]       clr_idex,
  output logic [1:0]       clr_exmem,
  output logic [1:0]       clr_memwb,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t state, state_nx;
  logic [MC_W-1:0] mc_cnt, mc_nx;
  logic waiting, mc_go, load_use;
  // release cycle (mc_cnt==0) in MC_WAIT behaves as RUN
  assign waiting = state == MC_WAIT && mc_cnt != '0;
  assign mc_go = ex_mc_start && ex_mc_lat >= MC_W'(2);
  assign load_use = ex_mem_read && ex_rd != '0 &&
    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  always_comb begin
    pc_we = 1'b1;
    clr_ifid = CLR_RUN;
    clr_idex = CLR_RUN;
    clr_exmem = CLR_RUN;
    clr_memwb = CLR_RUN;
    state_nx = RUN;
    mc_nx = mc_cnt;
    if (!rst_n) begin
      pc_we = 1'b0;
      clr_ifid = CLR_FLUSH;
      clr_idex = CLR_FLUSH;
      clr_exmem = CLR_FLUSH;
      clr_memwb = CLR_FLUSH;
    end else if (mem_busy) begin
      pc_we = 1'b0;
      clr_ifid = CLR_HOLD;
      clr_idex = CLR_HOLD;
      clr_exmem = CLR_HOLD;
      clr_memwb = CLR_FLUSH;
      state_nx = state;
    end else if (waiting || (mc_go && !ex_br_taken)) begin
      pc_we = 1'b0;
      clr_ifid = CLR_HOLD;
      clr_idex = CLR_HOLD;
      clr_exmem = CLR_FLUSH;
      state_nx = MC_WAIT;
      mc_nx = waiting ? mc_cnt - MC_W'(1) : ex_mc_lat - MC_W'(2);
    end else if (ex_br_taken) begin
      clr_ifid = CLR_FLUSH;
      clr_idex = CLR_FLUSH;
    end else if (load_use) begin
      pc_we = 1'b0;
      clr_ifid = CLR_HOLD;
      clr_idex = CLR_FLUSH;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      mc_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      mc_cnt <= mc_nx;
      stall_cnt <= stall_cnt + CNT_W'(!pc_we);
    end
  end
endmodule
